// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes (active-low, bit0=a .. bit6=g) and converter FSM states.
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} conv_state_t;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: one BCD digit plus blank flag to an active-low segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  logic [6:0] dig;
  always_comb begin
    dig = SEG_BLANK;
    case (bcd_i)
      4'd0: dig = SEG_0;
      4'd1: dig = SEG_1;
      4'd2: dig = SEG_2;
      4'd3: dig = SEG_3;
      4'd4: dig = SEG_4;
      4'd5: dig = SEG_5;
      4'd6: dig = SEG_6;
      4'd7: dig = SEG_7;
      4'd8: dig = SEG_8;
      4'd9: dig = SEG_9;
      default: dig = SEG_BLANK;
    endcase
  end
  assign seg_o = blank_i ? SEG_BLANK : dig;
endmodule

// File: rtl/bin_to_7segmt_conv.sv
// bin_to_7segmt_conv: sequential double-dabble binary-to-BCD with registered 7-segment outputs.
module bin_to_7segmt_conv
  import seg7_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int NDIG     = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic             Clk_signal,
  input  logic             Reset,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [6:0]       disp_0,
  output logic [6:0]       disp_1,
  output logic [6:0]       disp_2,
  output logic [6:0]       disp_3
);
  localparam int BW = 4*NDIG + 4;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W);
  localparam logic [6:0] LZ_RST = (BLANK_LZ != 0) ? SEG_BLANK : SEG_0;
  localparam logic [NDIG-1:0][6:0] DISP_RST = {{(NDIG-1){LZ_RST}}, SEG_0};
  conv_state_t state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, ovf_q, ovf_d;
  logic [NDIG-1:0][6:0] disp_q, disp_d, dec;
  logic [BW-1:0] bcd, adj;
  logic [NDIG-1:0] blank;
  logic lz, big;
  assign bcd = sr_q[SW-1:BIN_W];
  assign big = |bcd[BW-1:4*NDIG];
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BW/4; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    lz = (BLANK_LZ != 0);
    blank = '0;
    for (int i = NDIG-1; i > 0; i--) begin
      lz = lz & (bcd[4*i +: 4] == 4'd0);
      blank[i] = lz;
    end
  end
  for (genvar g = 0; g < NDIG; g++) begin : g_dec
    seg7_decoder u_dec (.bcd_i(bcd[4*g +: 4]), .blank_i(blank[g]), .seg_o(dec[g]));
  end
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        sr_d    = {{BW{1'b0}}, value};
        cnt_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        sr_d    = {adj[BW-2:0], sr_q[BIN_W-1:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(BIN_W-1)) ? LOAD : CONV;
      end
      LOAD: begin
        disp_d  = big ? {NDIG{SEG_DASH}} : dec;
        ovf_d   = big;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk_signal) begin
    if (!Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= DISP_RST;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
    end
  end
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign disp_0 = disp_q[0];
  assign disp_1 = disp_q[1];
  assign disp_2 = disp_q[2];
  assign disp_3 = disp_q[3];
endmodule

// File: tb/tb_bin_to_7segmt_conv.sv
// tb_bin_to_7segmt_conv: directed vectors with hand-computed segment patterns.
module tb_bin_to_7segmt_conv;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [13:0] value = '0;
  logic busy, done, ovf;
  logic [6:0] d0, d1, d2, d3;
  int checks = 0, failures = 0;
  localparam logic [6:0] B = 7'b1111111, D = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000;
  always #5 clk = ~clk;
  bin_to_7segmt_conv dut (
    .Clk_signal(clk), .Reset(rst_n), .start(start), .value(value),
    .busy(busy), .done(done), .ovf(ovf),
    .disp_0(d0), .disp_1(d1), .disp_2(d2), .disp_3(d3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [13:0] v, input logic [27:0] exp,
                     input logic exp_ovf, input bit inject);
    int n;
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    value = 14'($urandom);
    check({tag, ".busy"}, 32'(busy), 1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 2) begin
        start = 1'b1;
        value = 14'd42;
      end else if (inject && n == 3) start = 1'b0;
    end
    check({tag, ".latency"}, n, 15);
    check({tag, ".disp"}, {4'h0, d3, d2, d1, d0}, {4'h0, exp});
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, ".busy_end"}, 32'(busy), 0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 0);
  endtask
  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst.disp", {4'h0, d3, d2, d1, d0}, {4'h0, B, B, B, S0});
    check("rst.flags", {busy, done, ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("v1234", 14'd1234, {S1, S2, S3, S4}, 1'b0, 1'b0);
    run("v305", 14'd305, {B, S3, S0, S5}, 1'b0, 1'b0);
    run("v9999", 14'd9999, {S9, S9, S9, S9}, 1'b0, 1'b0);
    run("v10000", 14'd10000, {D, D, D, D}, 1'b1, 1'b0);
    run("v7", 14'd7, {B, B, B, S7}, 1'b0, 1'b0);
    run("v1000", 14'd1000, {S1, S0, S0, S0}, 1'b0, 1'b0);
    run("v0", 14'd0, {B, B, B, S0}, 1'b0, 1'b0);
    run("v16383", 14'd16383, {D, D, D, D}, 1'b1, 1'b0);
    run("ignore", 14'd305, {B, S3, S0, S5}, 1'b0, 1'b1);
    start = 1'b1;
    value = 14'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst.disp", {4'h0, d3, d2, d1, d0}, {4'h0, B, B, B, S0});
    check("midrst.flags", {busy, done, ovf}, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("midrst.no_done", 32'(seen), 0);
    run("after_rst", 14'd7, {B, B, B, S7}, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
